// File: rtl/regfile_pkg.sv
// Shared constants, operand-size encoding and byte-select helper for the register read port.
package regfile_pkg;

  localparam int unsigned REG_W     = 16;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic {
    SIZE_BYTE = 1'b0,
    SIZE_WORD = 1'b1
  } size_e;

  // Byte results are zero-extended into the low byte.
  function automatic logic [REG_W-1:0] byte_select(input logic [REG_W-1:0] word,
                                                   input size_e             size,
                                                   input logic              high);
    if (size == SIZE_WORD) begin
      return word;
    end
    return {8'h00, high ? word[15:8] : word[7:0]};
  endfunction

endpackage

// File: rtl/register_read_port_if.sv
// Request/response bundle of the register read port: read request handshake plus operand output.
interface register_read_port_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGISTERS = 8,
  parameter int unsigned TAG_W         = 4
);

  localparam int unsigned ID_W = $clog2(NUM_REGISTERS);

  logic             rd_valid;
  logic             rd_ready;
  logic [ID_W-1:0]  rd_id;
  logic             rd_size;
  logic             rd_high;
  logic [TAG_W-1:0] rd_tag;

  logic             out_valid;
  logic             out_ready;
  logic [REG_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output rd_valid, rd_id, rd_size, rd_high, rd_tag, out_ready,
    input  rd_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  rd_valid, rd_id, rd_size, rd_high, rd_tag, out_ready,
    output rd_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/reg_forward_mux.sv
// Post-edge register value for one id: file contents overridden by the two write ports
// (primary wins), then byte selection. Out-of-range ids read as zero.
module reg_forward_mux
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGISTERS = 8,
  localparam int unsigned ID_W         = $clog2(NUM_REGISTERS)
) (
  input  logic [REG_W-1:0] registers [NUM_REGISTERS],
  input  logic             we,
  input  logic [ID_W-1:0]  write_id,
  input  logic [REG_W-1:0] write_data,
  input  logic             we_secondary,
  input  logic [ID_W-1:0]  write_id_secondary,
  input  logic [REG_W-1:0] write_data_secondary,
  input  logic [ID_W-1:0]  id,
  input  size_e            size,
  input  logic             high,
  output logic [REG_W-1:0] value
);

  logic             in_range;
  logic [REG_W-1:0] word;

  if ((1 << ID_W) == NUM_REGISTERS) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (32'(id) < NUM_REGISTERS);
  end

  always_comb begin
    word = '0;
    if (in_range) begin
      word = registers[id];
      if (we_secondary && (write_id_secondary == id)) begin
        word = write_data_secondary;
      end
      if (we && (write_id == id)) begin
        word = write_data;
      end
    end
    value = byte_select(word, size, high);
  end

endmodule

// File: rtl/register_read_port.sv
// Buffered register read port: captures forwarded operands into a 2-entry FIFO.
// Define REG_READ_SNOOP_UPDATE_EN to keep buffered entries refreshed by later writes.
module register_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGISTERS = 8,
  parameter int unsigned TAG_W         = 4,
  localparam int unsigned ID_W         = $clog2(NUM_REGISTERS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_W-1:0]     registers [NUM_REGISTERS],
  input  logic                 we,
  input  logic [ID_W-1:0]      write_id,
  input  logic [REG_W-1:0]     write_data,
  input  logic                 we_secondary,
  input  logic [ID_W-1:0]      write_id_secondary,
  input  logic [REG_W-1:0]     write_data_secondary,
  register_read_port_if.slave  bus
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [REG_W-1:0] data_q [BUF_DEPTH];
  logic [REG_W-1:0] data_d [BUF_DEPTH];
  logic [TAG_W-1:0] tag_q  [BUF_DEPTH];
  logic [TAG_W-1:0] tag_d  [BUF_DEPTH];

  logic             accept;
  logic             dequeue;
  logic [REG_W-1:0] cap_value;

  // Handshake status depends on registered occupancy only.
  assign bus.rd_ready  = (count_q != CNT_W'(BUF_DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = data_q[head_q];
  assign bus.out_tag   = tag_q[head_q];

  assign accept  = bus.rd_valid && bus.rd_ready;
  assign dequeue = bus.out_valid && bus.out_ready;

  reg_forward_mux #(
    .NUM_REGISTERS (NUM_REGISTERS)
  ) u_capture_mux (
    .registers            (registers),
    .we                   (we),
    .write_id             (write_id),
    .write_data           (write_data),
    .we_secondary         (we_secondary),
    .write_id_secondary   (write_id_secondary),
    .write_data_secondary (write_data_secondary),
    .id                   (bus.rd_id),
    .size                 (size_e'(bus.rd_size)),
    .high                 (bus.rd_high),
    .value                (cap_value)
  );

`ifdef REG_READ_SNOOP_UPDATE_EN
  logic [ID_W-1:0]      id_q   [BUF_DEPTH];
  logic [ID_W-1:0]      id_d   [BUF_DEPTH];
  size_e                size_q [BUF_DEPTH];
  size_e                size_d [BUF_DEPTH];
  logic                 high_q [BUF_DEPTH];
  logic                 high_d [BUF_DEPTH];
  logic [REG_W-1:0]     upd_value [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] upd_en;

  for (genvar g = 0; g < BUF_DEPTH; g++) begin : g_snoop
    logic live;
    logic hit;

    reg_forward_mux #(
      .NUM_REGISTERS (NUM_REGISTERS)
    ) u_update_mux (
      .registers            (registers),
      .we                   (we),
      .write_id             (write_id),
      .write_data           (write_data),
      .we_secondary         (we_secondary),
      .write_id_secondary   (write_id_secondary),
      .write_data_secondary (write_data_secondary),
      .id                   (id_q[g]),
      .size                 (size_q[g]),
      .high                 (high_q[g]),
      .value                (upd_value[g])
    );

    assign live = (count_q == CNT_W'(BUF_DEPTH)) ||
                  ((count_q != '0) && (head_q == PTR_W'(g)));
    assign hit  = (we && (write_id == id_q[g])) ||
                  (we_secondary && (write_id_secondary == id_q[g]));
    assign upd_en[g] = live && hit && !(dequeue && (head_q == PTR_W'(g)));
  end
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    data_d  = data_q;
    tag_d   = tag_q;
`ifdef REG_READ_SNOOP_UPDATE_EN
    id_d    = id_q;
    size_d  = size_q;
    high_d  = high_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (upd_en[i]) begin
        data_d[i] = upd_value[i];
      end
    end
`endif

    // A fresh capture overrides any refresh of the tail slot.
    if (accept) begin
      data_d[tail_q] = cap_value;
      tag_d[tail_q]  = bus.rd_tag;
`ifdef REG_READ_SNOOP_UPDATE_EN
      id_d[tail_q]   = bus.rd_id;
      size_d[tail_q] = size_e'(bus.rd_size);
      high_d[tail_q] = bus.rd_high;
`endif
      tail_d = tail_q + PTR_W'(1);
    end

    if (dequeue) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({accept, dequeue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
`ifdef REG_READ_SNOOP_UPDATE_EN
        id_q[i]   <= '0;
        size_q[i] <= SIZE_BYTE;
        high_q[i] <= 1'b0;
`endif
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
`ifdef REG_READ_SNOOP_UPDATE_EN
      id_q    <= id_d;
      size_q  <= size_d;
      high_q  <= high_d;
`endif
    end
  end

endmodule

// File: tb/tb_register_read_port.sv
// Directed bench for register_read_port; a 6-register file leaves ids 6 and 7 out of range.
module tb_register_read_port;
  import regfile_pkg::*;

  localparam int unsigned NREG = 6;
  localparam int unsigned TW   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] regs [NREG];
  logic        we, we2;
  logic [2:0]  wid, wid2;
  logic [15:0] wdata, wdata2;

  int errors = 0;
  int checks = 0;

  register_read_port_if #(.NUM_REGISTERS(NREG), .TAG_W(TW)) bus ();

  register_read_port #(
    .NUM_REGISTERS (NREG),
    .TAG_W         (TW)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .registers            (regs),
    .we                   (we),
    .write_id             (wid),
    .write_data           (wdata),
    .we_secondary         (we2),
    .write_id_secondary   (wid2),
    .write_data_secondary (wdata2),
    .bus                  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic [2:0] id, input logic sz, input logic hi,
                     input logic [3:0] tag);
    bus.rd_valid = v;
    bus.rd_id    = id;
    bus.rd_size  = sz;
    bus.rd_high  = hi;
    bus.rd_tag   = tag;
  endtask

  initial begin
    regs[0] = 16'h0A0A; regs[1] = 16'h0001; regs[2] = 16'h2222;
    regs[3] = 16'hBEEF; regs[4] = 16'h4444; regs[5] = 16'h5555;
    we = 0; wid = 0; wdata = 0; we2 = 0; wid2 = 0; wdata2 = 0;
    req(0, 0, 0, 0, 0);
    bus.out_ready = 0;
    reset_n = 0;

    #12;
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_rd_ready",  32'(bus.rd_ready),  1);
    check("reset_out_data",  32'(bus.out_data),  0);
    check("reset_out_tag",   32'(bus.out_tag),   0);
    reset_n = 1;
    step();
    check("idle_out_valid", 32'(bus.out_valid), 0);

    // Word read, presented right after the accepting edge, gone one edge later.
    req(1, 3, 1, 0, 5);
    bus.out_ready = 1;
    step();
    check("word_valid", 32'(bus.out_valid), 1);
    check("word_data",  32'(bus.out_data),  32'h0000BEEF);
    check("word_tag",   32'(bus.out_tag),   5);
    req(0, 0, 0, 0, 0);
    step();
    check("word_drain", 32'(bus.out_valid), 0);

    // Both write ports hit the read id: primary wins.
    req(1, 2, 1, 0, 6);
    we = 1; wid = 2; wdata = 16'h1234;
    we2 = 1; wid2 = 2; wdata2 = 16'h5678;
    step();
    check("fwd_primary_data", 32'(bus.out_data), 32'h00001234);
    check("fwd_primary_tag",  32'(bus.out_tag),  6);
    we = 0; we2 = 0;

    // Byte reads overlapping the previous dequeue.
    req(1, 3, 0, 1, 7);
    step();
    check("byte_high_data",  32'(bus.out_data),  32'h000000BE);
    check("byte_high_tag",   32'(bus.out_tag),   7);
    check("byte_high_valid", 32'(bus.out_valid), 1);
    req(1, 3, 0, 0, 8);
    step();
    check("byte_low_data", 32'(bus.out_data), 32'h000000EF);
    check("byte_low_tag",  32'(bus.out_tag),  8);

    // Secondary port alone forwards; primary writes a different id.
    req(1, 4, 1, 0, 3);
    we = 1; wid = 5; wdata = 16'h9999;
    we2 = 1; wid2 = 4; wdata2 = 16'hABCD;
    step();
    check("fwd_secondary_data", 32'(bus.out_data), 32'h0000ABCD);
    we = 0; we2 = 0;

    // Out-of-range id reads zero but keeps its tag.
    req(1, 6, 1, 0, 9);
    step();
    check("oor_data",  32'(bus.out_data),  0);
    check("oor_tag",   32'(bus.out_tag),   9);
    check("oor_valid", 32'(bus.out_valid), 1);
    req(0, 0, 0, 0, 0);
    step();
    check("oor_drain", 32'(bus.out_valid), 0);

    // Back-pressure: fill both slots, third request held.
    bus.out_ready = 0;
    req(1, 0, 1, 0, 4'hA);
    step();
    check("bp_ready_after1", 32'(bus.rd_ready), 1);
    check("bp_tag_after1",   32'(bus.out_tag),  4'hA);
    req(1, 1, 1, 0, 4'hB);
    step();
    check("bp_ready_after2", 32'(bus.rd_ready), 0);
    req(1, 5, 1, 0, 4'hC);
    step();
    check("bp_held_ready", 32'(bus.rd_ready), 0);
    check("bp_held_tag",   32'(bus.out_tag),  4'hA);
    check("bp_held_data",  32'(bus.out_data), 32'h00000A0A);
    bus.out_ready = 1;
    step();
    check("bp_out_b_tag",  32'(bus.out_tag),  4'hB);
    check("bp_out_b_data", 32'(bus.out_data), 32'h00000001);
    check("bp_out_b_rdy",  32'(bus.rd_ready), 1);
    step();
    check("bp_out_c_tag",  32'(bus.out_tag),  4'hC);
    check("bp_out_c_data", 32'(bus.out_data), 32'h00005555);
    req(0, 0, 0, 0, 0);
    step();
    check("bp_drain", 32'(bus.out_valid), 0);

    // Buffered entry vs. a later write to the same register while stalled.
    bus.out_ready = 0;
    req(1, 1, 1, 0, 1);
    step();
    req(0, 0, 0, 0, 0);
    check("snoop_before", 32'(bus.out_data), 32'h00000001);
    we = 1; wid = 1; wdata = 16'h00FF;
    step();
    regs[1] = 16'h00FF;
    we = 0;
`ifdef REG_READ_SNOOP_UPDATE_EN
    check("snoop_after", 32'(bus.out_data), 32'h000000FF);
`else
    check("snoop_after", 32'(bus.out_data), 32'h00000001);
`endif

    // Asynchronous reset with two entries buffered.
    req(1, 3, 1, 0, 2);
    step();
    req(0, 0, 0, 0, 0);
    check("rst_full_ready", 32'(bus.rd_ready), 0);
    #2;
    reset_n = 0;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 0);
    check("rst_async_ready", 32'(bus.rd_ready),  1);
    check("rst_async_data",  32'(bus.out_data),  0);
    #3;
    reset_n = 1;
    step();
    check("rst_post_valid", 32'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
